mips_main_ctrl: RTL
===================

# mips_main_ctrl

Multicycle main controller for the MIPS datapath. It sits directly upstream of the register file and the rest of the datapath. It sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath enable, including `RegWrite`, which gates register-file writes. It also contains the ALU decoder, which maps `ALUOp` and `funct` to a 3-bit ALU control.

## Interface
Parameters:
- none; opcode and funct encodings are fixed to the MIPS subset below.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i_top`  in  1  system clock, rising edge.
- `rst_n_i_top`  in  1  asynchronous active-low reset.
- `op`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register load.
- `RegDst`  out  1  write-register select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  WD3 select: 0 = ALUOut, 1 = Data register.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  0 = PC, 1 = A.
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  PC load; combinational: PCWrite | (Branch & zero).
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse, in DECODE only, for an unsupported op or an R-type with an unsupported funct.
- `state`  out  4  current state encoding, for debug and bench.

## Operation
- Moore FSM with a 4-bit state register. All outputs except `PCEn` and `ALUControl` are decoded from the state alone.
- States and encodings:
  - RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12
- RST: all outputs are 0 and `ALUSrcB`=00. Next state is FETCH.
- FETCH: `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSrc`=00, PCWrite=1. Next state is DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. The branch target is computed, and the register file completes its registered read of rs/rt.
- Next state from DECODE, by `op`:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - anything else -> FETCH, with `illegal`=1
- MEMADR / ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. MEMADR goes to MEMRD for lw and to MEMWR for sw; ADDIEX goes to ADDIWB.
- MEMRD: `IorD`=1. Next state is MEMWB.
- MEMWB: `RegDst`=0, `MemtoReg`=1, `RegWrite`=1. Next state is FETCH.
- MEMWR: `IorD`=1, `MemWrite`=1. Next state is FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next state is ALUWB.
- ALUWB: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1. Next state is FETCH.
- ADDIWB: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1. Next state is FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, Branch=1, `PCSrc`=01. Next state is FETCH.
- JUMP: `PCSrc`=10, PCWrite=1. Next state is FETCH.
- ALU decoder (combinational):
  - `ALUOp`=00 -> 010; `ALUOp`=01 -> 110.
  - `ALUOp`=10 decodes `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - `ALUOp`=10 with any other funct -> 010.
- R-type funct checking: in DECODE, an R-type with an unsupported funct asserts `illegal` and returns to FETCH. It produces no write.
- Illegal state encodings (13-15) go to FETCH on the next edge, with all outputs at 0.

## Timing
- Reset: when `rst_n_i_top`=0, `state` becomes RST immediately, without waiting for a clock edge. All enables (`PCEn`, `IRWrite`, `MemWrite`, `RegWrite`) are 0 while reset is held. The first FETCH is the first rising edge after deassertion, plus one cycle in RST.
- Reset mid-instruction: the instruction is abandoned. No partial write may occur after reset asserts.
- Instruction latency, counted from FETCH to the next FETCH:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - illegal instruction 2
- `op` and `funct` are sampled only in DECODE. The IR is stable there because `IRWrite` is asserted only in FETCH.
- `PCEn` in BRANCH follows `zero` in the same cycle. The PC updates on the edge that ends BRANCH only when `zero`=1.
- `RegWrite` is high for exactly one cycle per writing instruction, in MEMWB, ALUWB or ADDIWB.
- `MemWrite` is high for exactly one cycle per sw.

## Test plan
- Reset during MEMWB of a lw, with `rst_n_i_top` low mid-cycle -> `state`=0 immediately and `RegWrite`=0 before the next edge. After release: one RST cycle, then FETCH with `IRWrite`=1 and `PCEn`=1.
- `op`=100011 -> state sequence 1,2,3,4,5,1. `RegWrite`=1 only in state 5, with `MemtoReg`=1 and `RegDst`=0.
- R-type with `funct`=101010 -> sequence 1,2,7,8,1. `ALUControl`=111 in EXEC. `RegWrite`=1 and `RegDst`=1 in ALUWB.
- beq with `zero`=1, then beq with `zero`=0 -> the first has `PCEn`=1 in BRANCH, the second has `PCEn`=0. `ALUControl`=110 in both. Each returns to FETCH after 3 cycles.
- sw, then j -> sw gives `MemWrite`=1 for one cycle in state 6 with `IorD`=1. j gives state 12 with `PCSrc`=10 and `PCEn`=1.
- `op`=111111, then R-type with `funct`=000111 -> each gives `illegal`=1 for one cycle in DECODE, returns to FETCH, and never asserts `RegWrite` or `MemWrite`.

Source files
------------

// File: rtl/mips_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath.
// The controller drives enables/selects and receives the IR fields and the ALU zero flag.
interface mips_main_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUControl, illegal, state
  );
endinterface

// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch..writeback plus the ALU decoder.
// Reset forces RST asynchronously so no enable can fire once rst_n_i_top drops.
module mips_main_ctrl (
  input  logic               clk_i_top,
  input  logic               rst_n_i_top,
  mips_main_ctrl_if.master   ctrl
);
  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       pc_write, branch, funct_ok;
  logic [1:0] alu_op;

  always_ff @(posedge clk_i_top or negedge rst_n_i_top) begin
    if (!rst_n_i_top) begin
      state_q <= S_RST;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    funct_ok = 1'b0;
    case (ctrl.funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = S_FETCH;
    is_sw_d       = is_sw_q;
    ctrl.IorD     = 1'b0;
    ctrl.MemWrite = 1'b0;
    ctrl.IRWrite  = 1'b0;
    ctrl.RegDst   = 1'b0;
    ctrl.MemtoReg = 1'b0;
    ctrl.RegWrite = 1'b0;
    ctrl.ALUSrcA  = 1'b0;
    ctrl.ALUSrcB  = 2'b00;
    ctrl.PCSrc    = 2'b00;
    ctrl.illegal  = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    alu_op        = 2'b00;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        ctrl.IRWrite = 1'b1;
        ctrl.ALUSrcB = 2'b01;
        pc_write     = 1'b1;
        state_d      = S_DECODE;
      end
      // op/funct are only consulted here; the sw/lw split is remembered for MEMADR.
      S_DECODE: begin
        ctrl.ALUSrcB = 2'b11;
        is_sw_d      = (ctrl.op == OP_SW);
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              state_d      = S_FETCH;
              ctrl.illegal = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = 2'b10;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.IorD = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.IorD     = 1'b1;
        ctrl.MemWrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.ALUSrcA = 1'b1;
        alu_op       = 2'b10;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_ADDIWB: ctrl.RegWrite = 1'b1;
      S_BRANCH: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.PCSrc   = 2'b01;
        alu_op       = 2'b01;
        branch       = 1'b1;
      end
      S_JUMP: begin
        ctrl.PCSrc = 2'b10;
        pc_write   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl.ALUControl = 3'b010;
    case (alu_op)
      2'b01: ctrl.ALUControl = 3'b110;
      2'b10: begin
        case (ctrl.funct)
          6'b100010: ctrl.ALUControl = 3'b110;
          6'b100100: ctrl.ALUControl = 3'b000;
          6'b100101: ctrl.ALUControl = 3'b001;
          6'b101010: ctrl.ALUControl = 3'b111;
          default:   ctrl.ALUControl = 3'b010;
        endcase
      end
      default: ctrl.ALUControl = 3'b010;
    endcase
  end

  assign ctrl.PCEn  = pc_write | (branch & ctrl.zero);
  assign ctrl.state = state_q;
endmodule
